multicycle_ctrl: RTL and testbench

- Moore-style main control FSM for the multicycle MIPS-subset datapath.
- Sits directly upstream of the register file: drives its write enable and write-address/write-data selects, plus PC, IR, memory and ALU controls.
- Sequences each instruction through IF/ID/EX/MEM/WB states, using opcode/funct from the IR and the ALU zero flag.

---
 rtl/ctrl_pkg.sv | 71 +++++++
 rtl/ctrl_out_decode.sv | 80 ++++++++
 rtl/multicycle_ctrl.sv | 109 ++++++++++
 tb/tb_multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle MIPS-subset control unit.
// MULTICYCLE_CTRL_HALT_EN makes OP_HALT a legal opcode.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_REXE  = 4'd6,
    S_RWB   = 4'd7,
    S_IEXE  = 4'd8,
    S_IWB   = 4'd9,
    S_BEQ   = 4'd10,
    S_JMP   = 4'd11,
    S_HALT  = 4'd12
  } stateT;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic [1:0] pcSource;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       extOp;
    logic [1:0] aluOp;
  } ctrlVecT;

  function automatic logic isLegalOp(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI: isLegalOp = 1'b1;
`ifdef MULTICYCLE_CTRL_HALT_EN
      OP_HALT: isLegalOp = 1'b1;
`endif
      default: isLegalOp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Purely combinational Moore decoder: current state and latched opcode to
// the datapath control vector. HALT and unused codes fall through to all-zero.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  stateT      state,
  input  logic [5:0] opQ,
  output ctrlVecT    ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.memRead = 1'b1;
        ctrl.irWrite = 1'b1;
        ctrl.pcWrite = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALU_ADD;
      end
      // Branch target is computed speculatively here and parked in ALUOut.
      S_ID: begin
        ctrl.aluSrcB = SRCB_IMM_SH;
        ctrl.extOp   = 1'b1;
      end
      S_MADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.extOp   = 1'b1;
      end
      S_MRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iOrD    = 1'b1;
      end
      S_MWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
      end
      S_MWR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iOrD     = 1'b1;
      end
      S_REXE: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      // ORI zero-extends its immediate; every other I-type sign-extends.
      S_IEXE: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        if (opQ == OP_ORI) begin
          ctrl.extOp = 1'b0;
          ctrl.aluOp = ALU_OR;
        end else begin
          ctrl.extOp = 1'b1;
          ctrl.aluOp = ALU_ADD;
        end
      end
      S_IWB: begin
        ctrl.regWrite = 1'b1;
      end
      S_BEQ: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluOp       = ALU_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
      end
      S_JMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main multicycle control FSM: state, op and funct registers plus reset gating.
// MULTICYCLE_CTRL_HALT_EN adds a HALT state entered from OP_HALT.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [1:0] alu_op,
  output logic [5:0] funct_q,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  stateT      stateQ;
  stateT      nextState;
  logic [5:0] opQ;
  ctrlVecT    decoded;
  ctrlVecT    ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= S_IF;
    else        stateQ <= nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opQ     <= '0;
      funct_q <= '0;
    end else if (stateQ == S_ID) begin
      opQ     <= opcode;
      funct_q <= funct;
    end
  end

  // Dispatch in ID uses the live IR opcode; later choices use the latched copy.
  always_comb begin
    nextState = S_IF;
    case (stateQ)
      S_IF: nextState = S_ID;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW:     nextState = S_MADDR;
          OP_RTYPE:         nextState = S_REXE;
          OP_ADDI, OP_ORI:  nextState = S_IEXE;
          OP_BEQ:           nextState = S_BEQ;
          OP_J:             nextState = S_JMP;
`ifdef MULTICYCLE_CTRL_HALT_EN
          OP_HALT:          nextState = S_HALT;
`endif
          default:          nextState = S_IF;
        endcase
      end
      S_MADDR: nextState = (opQ == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   nextState = S_MWB;
      S_REXE:  nextState = S_RWB;
      S_IEXE:  nextState = S_IWB;
`ifdef MULTICYCLE_CTRL_HALT_EN
      S_HALT:  nextState = S_HALT;
`endif
      default: nextState = S_IF;
    endcase
  end

  ctrl_out_decode uDecode (
    .state (stateQ),
    .opQ   (opQ),
    .ctrl  (decoded)
  );

  // Holding rst_n low kills every strobe combinationally, mid-instruction included.
  always_comb begin
    ctrl          = rst_n ? decoded : '0;
    pc_write      = ctrl.pcWrite;
    pc_write_cond = ctrl.pcWriteCond;
    pc_en         = ctrl.pcWrite | (ctrl.pcWriteCond & zero);
    pc_source     = ctrl.pcSource;
    ir_write      = ctrl.irWrite;
    mem_read      = ctrl.memRead;
    mem_write     = ctrl.memWrite;
    i_or_d        = ctrl.iOrD;
    reg_write     = ctrl.regWrite;
    reg_dst       = ctrl.regDst;
    mem_to_reg    = ctrl.memToReg;
    alu_src_a     = ctrl.aluSrcA;
    alu_src_b     = ctrl.aluSrcB;
    ext_op        = ctrl.extOp;
    alu_op        = ctrl.aluOp;
    illegal_op    = rst_n && (stateQ == S_ID) && !isLegalOp(opcode);
    state_o       = stateQ;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a random
// instruction stream against a per-instruction reference model.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_write, pc_write_cond, pc_en, ir_write, mem_read, mem_write;
  logic       i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a, ext_op, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [5:0] funct_q;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;
  bit prevRegWrite = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
    .pc_source(pc_source), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
    .funct_q(funct_q), .illegal_op(illegal_op), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] allOutputs();
    return {pc_write, pc_write_cond, pc_en, pc_source, ir_write, mem_read,
            mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a,
            alu_src_b, ext_op, alu_op, illegal_op};
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    prevRegWrite = 0;
  endtask

  // Runs one instruction from its IF cycle and checks every cycle against
  // the instruction-level model: state walk, strobe timing and mux settings.
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int expStates[$];
    int cpi;
    bit isLw, isSw, isR, isAddi, isOri, isBeq, isJ, writesReg;
    logic [7:0] expEn, gotEn;
    logic [9:0] expEx, gotEx;
    logic [1:0] expWb;
    isLw = (op == 6'h23); isSw = (op == 6'h2B); isR = (op == 6'h00);
    isAddi = (op == 6'h08); isOri = (op == 6'h0D); isBeq = (op == 6'h04);
    isJ = (op == 6'h02);
    if (isLw)               expStates = '{0, 1, 2, 3, 4};
    else if (isSw)          expStates = '{0, 1, 2, 5};
    else if (isR)           expStates = '{0, 1, 6, 7};
    else if (isAddi|isOri)  expStates = '{0, 1, 8, 9};
    else if (isBeq)         expStates = '{0, 1, 10};
    else if (isJ)           expStates = '{0, 1, 11};
    else                    expStates = '{0, 1};
    cpi = expStates.size();
    writesReg = isLw | isR | isAddi | isOri;
    opcode = op; funct = fn; zero = z;
    for (int c = 1; c <= cpi; c++) begin
      @(negedge clk);
      checks++;
      if (state_o !== 4'(expStates[c-1])) begin
        errors++;
        $display("[TB] FAIL state op=%h cyc=%0d got=%0d exp=%0d", op, c, state_o, expStates[c-1]);
      end
      expEn = {(c == 1) || (isJ && c == 3),
               (c == 1) || (isJ && c == 3) || (isBeq && c == 3 && z),
               c == 1,
               (c == 1) || (isLw && c == 4),
               isSw && c == 4,
               (isLw || isSw) && c == 4,
               writesReg && c == cpi,
               (cpi == 2) && c == 2};
      gotEn = {pc_write, pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write, illegal_op};
      checks++;
      if (gotEn !== expEn) begin
        errors++;
        $display("[TB] FAIL enables op=%h cyc=%0d got=%b exp=%b", op, c, gotEn, expEn);
      end
      checks++;
      if (prevRegWrite && reg_write) begin
        errors++;
        $display("[TB] FAIL regwrite_back2back op=%h cyc=%0d got=1 exp=0", op, c);
      end
      prevRegWrite = reg_write;
      if (c == 1) begin
        checks++;
        if ({alu_src_b, alu_op} !== 4'b0100) begin
          errors++;
          $display("[TB] FAIL if_alu got=%b exp=0100", {alu_src_b, alu_op});
        end
      end
      if (c == 2) begin
        checks++;
        if ({alu_src_b, ext_op} !== 3'b111) begin
          errors++;
          $display("[TB] FAIL id_alu got=%b exp=111", {alu_src_b, ext_op});
        end
      end
      if (c >= 3) begin
        checks++;
        if (funct_q !== fn) begin
          errors++;
          $display("[TB] FAIL funct_q op=%h got=%h exp=%h", op, funct_q, fn);
        end
      end
      if (c == 3) begin
        // {alu_src_a, alu_src_b, ext_op, alu_op, pc_source, pc_write_cond}
        if (isR)         expEx = 10'b1_00_0_10_00_0;
        else if (isAddi) expEx = 10'b1_10_1_00_00_0;
        else if (isOri)  expEx = 10'b1_10_0_11_00_0;
        else if (isBeq)  expEx = 10'b1_00_0_01_01_1;
        else if (isJ)    expEx = 10'b0_00_0_00_10_0;
        else             expEx = 10'b1_10_1_00_00_0;
        gotEx = {alu_src_a, alu_src_b, ext_op, alu_op, pc_source, pc_write_cond};
        checks++;
        if (gotEx !== expEx) begin
          errors++;
          $display("[TB] FAIL exec_ctrl op=%h got=%b exp=%b", op, gotEx, expEx);
        end
      end
      if (writesReg && c == cpi) begin
        expWb = isLw ? 2'b01 : (isR ? 2'b10 : 2'b00);
        checks++;
        if ({reg_dst, mem_to_reg} !== expWb) begin
          errors++;
          $display("[TB] FAIL wb_sel op=%h got=%b exp=%b", op, {reg_dst, mem_to_reg}, expWb);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'h23; funct = 6'h00; zero = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({allOutputs(), state_o} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%h exp=0", {allOutputs(), state_o});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if ({state_o, ir_write, pc_write} !== 6'b0000_11) begin
      errors++;
      $display("[TB] FAIL reset_first_if got=%b exp=000011", {state_o, ir_write, pc_write});
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'h23; funct = 6'h11; zero = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if ({state_o, mem_read} !== 5'b0011_1) begin
      errors++;
      $display("[TB] FAIL mid_pre_state got=%b exp=00111", {state_o, mem_read});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({allOutputs(), state_o} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs got=%h exp=0", {allOutputs(), state_o});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    prevRegWrite = 0;
  endtask

  task automatic test_lw();      runInstr(6'h23, 6'h00, 1'b0); endtask
  task automatic test_rtype();   runInstr(6'h00, 6'h20, 1'b0); endtask
  task automatic test_beq();     runInstr(6'h04, 6'h00, 1'b1); runInstr(6'h04, 6'h00, 1'b0); endtask
  task automatic test_ori_addi(); runInstr(6'h0D, 6'h05, 1'b0); runInstr(6'h08, 6'h3A, 1'b1); endtask
  task automatic test_sw();      runInstr(6'h2B, 6'h00, 1'b1); endtask
  task automatic test_jump();    runInstr(6'h02, 6'h07, 1'b1); endtask

  task automatic test_opcode_3f();
`ifdef MULTICYCLE_CTRL_HALT_EN
    opcode = 6'h3F; funct = 6'h00; zero = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({state_o, illegal_op} !== 5'b0001_0) begin
      errors++;
      $display("[TB] FAIL halt_id got=%b exp=00010", {state_o, illegal_op});
    end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({state_o, allOutputs()} !== {4'd12, 20'h0}) begin
        errors++;
        $display("[TB] FAIL halt_hold cyc=%0d got=%h exp=%h", i, {state_o, allOutputs()}, {4'd12, 20'h0});
      end
    end
    doReset();
`else
    runInstr(6'h3F, 6'h00, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [7];
    logic [5:0] op;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0D};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 7) op = 6'($urandom_range(0, 63));
      else op = ops[$urandom_range(0, 6)];
`ifdef MULTICYCLE_CTRL_HALT_EN
      if (op == 6'h3F) op = 6'h3E;
`endif
      runInstr(op, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("[TB] FAIL final_if got=%0d exp=0", state_o);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_ori_addi();
    test_sw();
    test_jump();
    test_opcode_3f();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
